// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_arbiter two-port data-memory arbiter.
package dm_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dm_arb_rr2.sv
// Two-way round-robin picker: on a tie the port that did not win last time wins.
module dm_arb_rr2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == REQ_CPU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and DMA/debug (port 1).
// Ownership locking is built only when DM_ARB_LOCK_EN is defined.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
`ifdef DM_ARB_LOCK_EN
    input  logic              r0_lock,
    input  logic              r1_lock,
`endif
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    // Word-aligns the address: the low two byte-offset bits never reach the memory.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_last_gnt;
    logic [1:0]        w_lock;
    logic [1:0]        w_rr_gnt;
    logic [1:0]        w_gnt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

`ifdef DM_ARB_LOCK_EN
    assign w_lock = {r1_lock, r0_lock};
`else
    assign w_lock = 2'b00;
`endif

    dm_arb_rr2 u_rr2 (
        .req      ({r1_req, r0_req}),
        .last_gnt (r_last_gnt),
        .gnt      (w_rr_gnt)
    );

    always_comb begin
        w_gnt       = 2'b00;
        w_state_nxt = r_state;
        case (r_state)
            LOCK0: begin
                w_gnt = {1'b0, r0_req};
                if (!w_lock[0]) w_state_nxt = ARB;
            end
            LOCK1: begin
                w_gnt = {r1_req, 1'b0};
                if (!w_lock[1]) w_state_nxt = ARB;
            end
            default: begin
                w_gnt = w_rr_gnt;
                if (w_rr_gnt[0] && w_lock[0])      w_state_nxt = LOCK0;
                else if (w_rr_gnt[1] && w_lock[1]) w_state_nxt = LOCK1;
            end
        endcase
        // Reset wins over everything, so a coinciding write never reaches the memory.
        if (reset) begin
            w_gnt       = 2'b00;
            w_state_nxt = ARB;
        end
    end

    always_comb begin
        mem_write   = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        if (w_gnt[0]) begin
            mem_write   = r0_we;
            mem_address = r0_addr & WORD_MASK;
            mem_data_in = r0_wdata;
        end else if (w_gnt[1]) begin
            mem_write   = r1_we;
            mem_address = r1_addr & WORD_MASK;
            mem_data_in = r1_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ARB;
            r_last_gnt <= REQ_DMA;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            if (|w_gnt) r_last_gnt <= w_gnt[1];
            r_rvalid0 <= w_gnt[0] & ~r0_we;
            r_rvalid1 <= w_gnt[1] & ~r1_we;
            if (w_gnt[0] && !r0_we) r_rdata0 <= mem_data_out;
            if (w_gnt[1] && !r1_we) r_rdata1 <= mem_data_out;
        end
    end

    assign r0_gnt    = w_gnt[0];
    assign r1_gnt    = w_gnt[1];
    assign r0_rvalid = r_rvalid0;
    assign r1_rvalid = r_rvalid1;
    assign r0_rdata  = r_rdata0;
    assign r1_rdata  = r_rdata1;
    assign busy      = (|w_gnt) | ((r_state != ARB) & ~reset);

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_dm_arbiter;

    logic        clock = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        lock  [2];

    logic        r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_write, busy;
    logic [31:0] r0_rdata, r1_rdata, mem_address, mem_data_in, mem_data_out;

    assign r0_req = req[0];   assign r1_req = req[1];
    assign r0_we = we[0];     assign r1_we = we[1];
    assign r0_addr = addr[0]; assign r1_addr = addr[1];
    assign r0_wdata = wdata[0]; assign r1_wdata = wdata[1];
    assign r0_lock = lock[0]; assign r1_lock = lock[1];

    always #5 clock = ~clock;

    dm_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (rst),
        .r0_req       (r0_req),
        .r0_we        (r0_we),
        .r0_addr      (r0_addr),
        .r0_wdata     (r0_wdata),
        .r1_req       (r1_req),
        .r1_we        (r1_we),
        .r1_addr      (r1_addr),
        .r1_wdata     (r1_wdata),
`ifdef DM_ARB_LOCK_EN
        .r0_lock      (r0_lock),
        .r1_lock      (r1_lock),
`endif
        .r0_gnt       (r0_gnt),
        .r1_gnt       (r1_gnt),
        .r0_rdata     (r0_rdata),
        .r1_rdata     (r1_rdata),
        .r0_rvalid    (r0_rvalid),
        .r1_rvalid    (r1_rvalid),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    // 4 KB single-port memory standing in for dm: combinational read, write at the edge.
    logic        tb_clr;
    logic [31:0] dmem [1024];
    always @(posedge clock) begin
        if (tb_clr) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'h0;
        end else if (mem_write) begin
            dmem[mem_address[11:2]] <= mem_data_in;
        end
    end
    assign mem_data_out = dmem[mem_address[11:2]];

    // Reference model: who owns the memory, who won last, what each port should read.
    int          n_chk = 0, n_pass = 0;
    int          m_last = 1, m_lock = -1, exp_w;
    bit          m_ok = 0;
    logic        m_rv [2];
    logic [31:0] m_rd [2];
    logic [31:0] ref_mem [1024];
    logic [1:0]  obs_gnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    task automatic cycle();
        int w;
        #2;
        w = -1;
        if (!rst) begin
            if (m_lock >= 0) begin
                if (req[m_lock]) w = m_lock;
            end else if (req[0] && req[1]) w = 1 - m_last;
            else if (req[0]) w = 0;
            else if (req[1]) w = 1;
        end
        chk("gnt", {30'h0, r1_gnt, r0_gnt}, {30'h0, w == 1, w == 0});
        chk("mem_write", {31'h0, mem_write}, {31'h0, (w >= 0) ? we[w] : 1'b0});
        chk("mem_addr", mem_address, (w >= 0) ? {addr[w][31:2], 2'b00} : 32'h0);
        chk("mem_din", mem_data_in, (w >= 0) ? wdata[w] : 32'h0);
        chk("busy", {31'h0, busy}, {31'h0, !rst && (w >= 0 || m_lock >= 0)});
        if (m_ok) begin
            chk("rvalid0", {31'h0, r0_rvalid}, {31'h0, m_rv[0]});
            chk("rvalid1", {31'h0, r1_rvalid}, {31'h0, m_rv[1]});
            chk("rdata0", r0_rdata, m_rd[0]);
            chk("rdata1", r1_rdata, m_rd[1]);
        end
        obs_gnt = {r1_gnt, r0_gnt};
        exp_w   = w;
        @(posedge clock);
        #1;
        if (rst) begin
            m_last = 1; m_lock = -1; m_ok = 1;
            m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
        end else begin
            m_rv[0] = 0; m_rv[1] = 0;
            if (w >= 0) begin
                m_last = w;
                if (we[w]) ref_mem[addr[w][11:2]] = wdata[w];
                else begin
                    m_rv[w] = 1;
                    m_rd[w] = ref_mem[addr[w][11:2]];
                end
            end
            if (m_lock >= 0) begin
                if (!lock[m_lock]) m_lock = -1;
            end else if (w >= 0 && lock[w]) m_lock = w;
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic wr,
                            input logic [31:0] a, input logic [31:0] d, input logic l);
        req[p] = r; we[p] = wr; addr[p] = a; wdata[p] = d; lock[p] = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        bit pend [2];
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        rst = 1; tb_clr = 1;
        cycle(); cycle();
        tb_clr = 0; rst = 0;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rdata1", r1_rdata, 32'h0);

        // Port 0 writes, port 1 reads back the same word.
        set_port(0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
        cycle();
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 1, 0, 32'h10, 32'h0, 0);
        cycle();
        set_port(1, 0, 0, 0, 0, 0);
        chk("raw_rvalid", {31'h0, r1_rvalid}, 32'h1);
        chk("raw_rdata", r1_rdata, 32'hDEADBEEF);
        cycle();

        // Continuous contention right after reset alternates 0,1,0,1...
        rst = 1; cycle(); rst = 0;
        set_port(0, 1, 0, 32'h10, 0, 0);
        set_port(1, 1, 0, 32'h20, 0, 0);
        c0 = 0; c1 = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_seq", {30'h0, obs_gnt}, (i % 2 == 0) ? 32'h1 : 32'h2);
            c0 += int'(obs_gnt[0]); c1 += int'(obs_gnt[1]);
        end
        chk("rr_cnt0", c0, 4);
        chk("rr_cnt1", c1, 4);
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        cycle();

        // Byte-offset bits select the same word.
        set_port(1, 1, 1, 32'h7, 32'h12345678, 0);
        cycle();
        set_port(1, 0, 0, 0, 0, 0);
        set_port(0, 1, 0, 32'h4, 0, 0);
        cycle();
        set_port(0, 0, 0, 0, 0, 0);
        chk("lowbits_rdata", r0_rdata, 32'h12345678);
        cycle();

`ifdef DM_ARB_LOCK_EN
        // Port 0 locks for three reads; port 1 waits until the lock drops.
        rst = 1; cycle(); rst = 0;
        set_port(1, 1, 0, 32'h10, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_port(0, 1, 0, 32'h4 + 32'(i * 4), 0, i < 2);
            cycle();
            chk("lock_hold", {30'h0, obs_gnt}, 32'h1);
        end
        set_port(0, 0, 0, 0, 0, 0);
        cycle();
        chk("lock_release", {30'h0, obs_gnt}, 32'h2);
        set_port(1, 0, 0, 0, 0, 0);
        cycle();

        // Reset while port 1 holds the lock with a read in flight.
        set_port(1, 1, 0, 32'h10, 0, 1);
        cycle(); cycle();
        rst = 1; cycle(); rst = 0;
        chk("rstlk_rvalid", {30'h0, r1_rvalid, r0_rvalid}, 32'h0);
        chk("rstlk_rdata1", r1_rdata, 32'h0);
        chk("rstlk_rdata0", r0_rdata, 32'h0);
        set_port(0, 1, 0, 32'h8, 0, 0);
        set_port(1, 1, 0, 32'h10, 0, 0);
        cycle();
        chk("rstlk_tie", {30'h0, obs_gnt}, 32'h1);
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
        cycle();
`endif

        // Idle: nothing moves.
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle", {29'h0, mem_write, busy, r0_rvalid | r1_rvalid}, 32'h0);
        end

        // Random traffic; a request is held until the model says it was granted.
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    req[p]   = ($urandom % 3) != 0;
                    we[p]    = $urandom % 2 == 1;
                    addr[p]  = $urandom_range(0, 63);
                    wdata[p] = $urandom;
                    pend[p]  = req[p];
                end
`ifdef DM_ARB_LOCK_EN
                lock[p] = ($urandom % 4) == 0;
`endif
            end
            rst = ($urandom % 64) == 0;
            cycle();
            for (int p = 0; p < 2; p++) if (exp_w == p) pend[p] = 0;
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
